// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared types, constants and opcode decode for the acc_seq operation sequencer
package acc_seq_pkg;
  localparam int SEQ_WIDTH = 4;
  localparam int SEQ_REP_W = 2;
  localparam logic IDLE_SEL0 = 1'b0;
  localparam logic IDLE_SEL1 = 1'b0;
  typedef enum logic [1:0] {ADD, SUB, LOAD, LOADINV} op_t;
  typedef struct packed {
    op_t                  op;
    logic [SEQ_WIDTH-1:0] data;
    logic [SEQ_REP_W-1:0] rep;
  } seq_entry_t;
  typedef enum logic {IDLE, ISSUE} state_t;
  function automatic logic [1:0] op_to_sel(op_t op);
    return {op == LOAD || op == LOADINV, op == SUB || op == LOADINV};
  endfunction
endpackage

// File: rtl/acc_seq_fifo.sv
// seq_fifo: request buffer of seq_entry_t with extra-bit pointers for full/empty
module seq_fifo
  import acc_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  seq_entry_t wdata_i,
  input  logic       pop_i,
  output seq_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  seq_entry_t mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/acc_seq.sv
// acc_seq: buffers op requests and drives the accumulator datapath one op per clock.
// Define ACC_SEQ_ISSUE_CNT_EN to add the saturating issue_cnt output.
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = 4,
  parameter int REP_W = SEQ_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_rep,
  input  logic             clr_flags,
  input  logic             dp_cout,
  output logic [WIDTH-1:0] dp_a,
  output logic             dp_sel0,
  output logic             dp_sel1,
  output logic             busy,
  output logic             carry_flag
`ifdef ACC_SEQ_ISSUE_CNT_EN
  ,
  output logic [7:0]       issue_cnt
`endif
);
  state_t state_q, state_d;
  seq_entry_t cur_q, cur_d, head;
  logic [WIDTH-1:0] dp_a_q, dp_a_d;
  logic [1:0] sel_q, sel_d;
  logic carry_q, carry_d, full, empty, push, pop, issuing;
  assign issuing    = state_q == ISSUE;
  assign push       = in_valid && !full;
  assign pop        = !empty && (!issuing || cur_q.rep == '0);
  assign in_ready   = reset && !full;
  assign busy       = issuing || !empty;
  assign dp_a       = dp_a_q;
  assign dp_sel1    = sel_q[1];
  assign dp_sel0    = sel_q[0];
  assign carry_flag = carry_q;
  seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i ('{op: op_t'(in_op), data: in_data, rep: in_rep}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_comb begin
    cur_d   = cur_q;
    state_d = state_q;
    if (pop) begin
      cur_d   = head;
      state_d = ISSUE;
    end else if (issuing && cur_q.rep != '0) cur_d.rep = cur_q.rep - REP_W'(1);
    else state_d = IDLE;
    dp_a_d  = state_d == ISSUE ? cur_d.data : '0;
    sel_d   = state_d == ISSUE ? op_to_sel(cur_d.op) : {IDLE_SEL1, IDLE_SEL0};
    // set beats clear when a carry lands in the same cycle as clr_flags
    carry_d = (issuing && (cur_q.op == ADD || cur_q.op == SUB) && dp_cout) || (carry_q && !clr_flags);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      dp_a_q  <= '0;
      sel_q   <= {IDLE_SEL1, IDLE_SEL0};
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dp_a_q  <= dp_a_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
    end
  end
`ifdef ACC_SEQ_ISSUE_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d     = clr_flags ? {7'd0, issuing} : cnt_q + {7'd0, issuing && cnt_q != 8'hFF};
  assign issue_cnt = cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule
